// File: rtl/mul_seq_pkg.sv
// Shared encodings for the iterative shift-add multiplier sequencer.
// Handshake level names mirror the divider's Div* constants.
package mul_seq_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [1:0] MulTypeMUL    = 2'b00;
    localparam logic [1:0] MulTypeMULH   = 2'b01;
    localparam logic [1:0] MulTypeMULHSU = 2'b10;
    localparam logic [1:0] MulTypeMULHU  = 2'b11;

    localparam logic MulResultReady    = 1'b1;
    localparam logic MulResultNotReady = 1'b0;
    localparam logic MulStart          = 1'b1;
    localparam logic MulStop           = 1'b0;

    typedef enum logic [1:0] {
        MulIdle = 2'b00,
        MulCalc = 2'b01,
        MulDone = 2'b10
    } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// EX-stage <-> multiplier handshake bundle; master is the EX stage, slave is mul_seq.
interface mul_seq_if #(
    parameter int XLEN = 32
);
    logic                  start_i;
    logic                  annul_i;
    logic [1:0]            mul_type_i;
    logic [XLEN-1:0]       opdata1_i;
    logic [XLEN-1:0]       opdata2_i;
    logic [2*XLEN-1:0]     result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output start_i, annul_i, mul_type_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, mul_type_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative 32x32 shift-add multiplier with sign handling and a 64-bit {hi,lo} product.
// Optional macro MUL_SEQ_EARLY_OUT_EN finishes CALC as soon as the remaining multiplier is zero.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic       clk,
    input logic       rst,
    mul_seq_if.slave  bus
);

    mul_state_e          state_r, state_s;
    logic [2*XLEN-1:0]   mcand_r, mcand_s;
    logic [XLEN-1:0]     mplier_r, mplier_s;
    logic [2*XLEN-1:0]   acc_r, acc_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                neg_r, neg_s;
    logic [2*XLEN-1:0]   result_r, result_s;
    logic                ready_r, ready_s;
    logic                busy_r, busy_s;

    logic                op1_neg_s, op2_neg_s;
    logic [XLEN-1:0]     mag1_s, mag2_s;
    logic [XLEN-1:0]     mplier_shr_s;

    // Two's-complement magnitude; the most negative value maps to itself read as unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] m;
        if (neg) begin
            m = (~v) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Operand sign interpretation and magnitudes, used only on the IDLE start edge.
    always_comb begin
        op1_neg_s    = (bus.mul_type_i != MulTypeMULHU) && bus.opdata1_i[XLEN-1];
        op2_neg_s    = ((bus.mul_type_i == MulTypeMUL) || (bus.mul_type_i == MulTypeMULH))
                       && bus.opdata2_i[XLEN-1];
        mag1_s       = magnitude(bus.opdata1_i, op1_neg_s);
        mag2_s       = magnitude(bus.opdata2_i, op2_neg_s);
        mplier_shr_s = mplier_r >> 1;
    end

    // Next-state, datapath and output-register next values.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        neg_s    = neg_r;
        result_s = result_r;
        ready_s  = ready_r;
        case (state_r)
            MulIdle: begin
                result_s = {(2*XLEN){1'b0}};
                ready_s  = MulResultNotReady;
                if ((bus.start_i == MulStart) && !bus.annul_i) begin
                    acc_s = {(2*XLEN){1'b0}};
                    cnt_s = {CNT_W{1'b0}};
                    if ((bus.opdata1_i == {XLEN{1'b0}}) || (bus.opdata2_i == {XLEN{1'b0}})) begin
                        neg_s   = 1'b0;
                        state_s = MulDone;
                    end else begin
                        neg_s    = op1_neg_s ^ op2_neg_s;
                        mcand_s  = {{XLEN{1'b0}}, mag1_s};
                        mplier_s = mag2_s;
                        state_s  = MulCalc;
                    end
                end else begin
                    state_s = MulIdle;
                end
            end
            MulCalc: begin
                result_s = {(2*XLEN){1'b0}};
                ready_s  = MulResultNotReady;
                if (bus.annul_i) begin
                    state_s = MulIdle;
                end else begin
                    if (mplier_r[0]) begin
                        acc_s = acc_r + mcand_r;
                    end else begin
                        acc_s = acc_r;
                    end
                    mcand_s  = mcand_r << 1;
                    mplier_s = mplier_shr_s;
                    cnt_s    = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(XLEN - 1)) begin
                        state_s = MulDone;
`ifdef MUL_SEQ_EARLY_OUT_EN
                    end else if (mplier_shr_s == {XLEN{1'b0}}) begin
                        state_s = MulDone;
`endif
                    end else begin
                        state_s = MulCalc;
                    end
                end
            end
            MulDone: begin
                if (bus.annul_i || (bus.start_i == MulStop)) begin
                    state_s  = MulIdle;
                    result_s = {(2*XLEN){1'b0}};
                    ready_s  = MulResultNotReady;
                end else begin
                    state_s  = MulDone;
                    result_s = neg_r ? ((~acc_r) + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_r;
                    ready_s  = MulResultReady;
                end
            end
            default: begin
                state_s  = MulIdle;
                result_s = {(2*XLEN){1'b0}};
                ready_s  = MulResultNotReady;
            end
        endcase
        busy_s = (state_s != MulIdle);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= MulIdle;
            mcand_r  <= {(2*XLEN){1'b0}};
            mplier_r <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            neg_r    <= 1'b0;
            result_r <= {(2*XLEN){1'b0}};
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            neg_r    <= neg_s;
            result_r <= result_s;
            ready_r  <= ready_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;
    assign bus.busy_o   = busy_r;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: randomized and directed multiplies against an arithmetic model.
// Expected latency follows MUL_SEQ_EARLY_OUT_EN when the macro is defined.
module tb_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mul_seq_if #(.XLEN(32)) bus ();

    mul_seq #(.XLEN(32), .CNT_W(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic ready_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // True product: sign-extend each operand as its type says and multiply in 64 bits.
    function automatic logic [63:0] ref_prod(input logic [1:0] t, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb;
        sa = (t == 2'b11) ? longint'({32'd0, a}) : longint'(signed'(a));
        sb = (t[1] == 1'b0) ? longint'(signed'(b)) : longint'({32'd0, b});
        return sa * sb;
    endfunction

    function automatic int ref_lat(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_OUT_EN
        logic [31:0] mag;
        int          hi;
`endif
        if (a == 32'd0 || b == 32'd0) return 1;
`ifdef MUL_SEQ_EARLY_OUT_EN
        mag = (t[1] == 1'b0 && b[31]) ? (32'd0 - b) : b;
        hi  = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) hi = i;
        return hi + 2;
`else
        return (t == 2'b11) ? 33 : 33;
`endif
    endfunction

    // Monitor: every rising ready_o must match the oldest outstanding request.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && bus.ready_o && !ready_prev) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: got result %h, required no output", bus.result_o);
            end else begin
                e = sb_q.pop_front();
                check("product", bus.result_o, e.prod);
                check("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
        ready_prev <= bus.ready_o;
    end

    task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        exp_t e;
        bus.mul_type_i = t;
        bus.opdata1_i  = a;
        bus.opdata2_i  = b;
        bus.start_i    = 1'b1;
        bus.annul_i    = 1'b0;
        if (push) begin
            e.prod = ref_prod(t, a, b);
            e.lat  = ref_lat(t, a, b);
            e.t0   = cyc + 1;
            sb_q.push_back(e);
        end
    endtask

    // Hold start until ready, scramble operands meanwhile, then release and check the clear.
    task automatic finish_op(input int hold);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited == 1) begin
                bus.mul_type_i = 2'($urandom_range(0, 3));
                bus.opdata1_i  = $urandom;
                bus.opdata2_i  = $urandom;
            end
        end while (!bus.ready_o && waited < 80);
        if (!bus.ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, required ready", waited);
        end else begin
            check("busy_in_done", 64'(bus.busy_o), 64'd1);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("ready_held", 64'(bus.ready_o), 64'd1);
            end
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        check("ready_clear", 64'(bus.ready_o), 64'd0);
        check("result_clear", bus.result_o, 64'd0);
        check("busy_clear", 64'(bus.busy_o), 64'd0);
    endtask

    task automatic do_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        @(negedge clk);
        issue(t, a, b, 1'b1);
        finish_op(hold);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 15));
            4:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start_i    = 1'b0;
        bus.annul_i    = 1'b0;
        bus.mul_type_i = 2'b00;
        bus.opdata1_i  = 32'd0;
        bus.opdata2_i  = 32'd0;
        #12;
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 3);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1);
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(2'b00, 32'h1234_5678, 32'h0000_0000, 2);
        do_op(2'b11, 32'h0000_0005, 32'h0000_0007, 0);
        do_op(2'b01, 32'h0000_0000, 32'h8000_0000, 0);

        // start together with annul in IDLE must be ignored
        @(negedge clk);
        issue(2'b11, 32'd9, 32'd9, 1'b0);
        bus.annul_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_annul_busy", 64'(bus.busy_o), 64'd0);
        end
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;

        // annul mid-CALC, then a fresh request right behind it
        @(negedge clk);
        issue(2'b00, 32'hDEAD_BEEF, 32'h0001_2345, 1'b0);
        repeat (11) @(negedge clk);
        check("busy_mid_calc", 64'(bus.busy_o), 64'd1);
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("annul_busy", 64'(bus.busy_o), 64'd0);
        check("annul_ready", 64'(bus.ready_o), 64'd0);
        check("annul_result", bus.result_o, 64'd0);
        issue(2'b10, 32'h8765_4321, 32'hC000_0003, 1'b1);
        finish_op(1);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        issue(2'b11, 32'h0BAD_F00D, 32'h7FFF_FFFF, 1'b0);
        repeat (6) @(negedge clk);
        check("busy_before_rst", 64'(bus.busy_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd0);
        check("rst_result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                  int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no completion, required summary before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative 32x32 shift-add multiplier sequencer for the EX stage.
- Replaces the single-cycle combinational multiply path for MUL/MULH/MULHSU/MULHU.
- Uses the same start/ready/stall handshake as the divider:
  - EX holds start_i high and raises stallreq until ready_o pulses.
  - EX then drops start_i.
- Handles sign conversion internally and returns the full 64-bit product.

Parameters:
- XLEN, 32, operand width. Product is 2*XLEN. Only 32 is supported.
- CNT_W, 6, iteration counter width. Must satisfy CNT_W >= clog2(XLEN)+1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset; block is in reset while rst==0
- start_i  in  1  request; held high by EX until ready_o seen
- annul_i  in  1  flush/exception cancel; aborts any operation in progress
- mul_type_i  in  2  00 MUL (s*s), 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
- opdata1_i  in  32  rs1 operand
- opdata2_i  in  32  rs2 operand
- result_o  out  64  product, {hi,lo}; valid only while ready_o==1
- ready_o  out  1  result valid
- busy_o  out  1  high in CALC or DONE

Behaviour:
- Reset values (async, rst==0): state=IDLE; result_o=0; ready_o=0; busy_o=0; all internal registers 0.
- Operands are sampled once, in IDLE on the start edge. Later changes to opdata*_i or mul_type_i are ignored until the block returns to IDLE.
- Sign rules:
  - op1 is signed for MUL, MULH, MULHSU.
  - op2 is signed for MUL, MULH.
  - Negative signed operands are converted to magnitude (two's complement). 0x80000000 becomes magnitude 0x80000000, unsigned.
  - neg_flag = sign(op1 eff) XOR sign(op2 eff).
- IDLE:
  - start_i=1 and annul_i=0, and either operand is 0: go to DONE next cycle with product 0 (fast path).
  - start_i=1 and annul_i=0 otherwise: load mcand={32'b0,|op1|}, mplier=|op2|, acc=0, cnt=0; go to CALC.
  - Anything else: stay in IDLE.
- CALC, once per cycle:
  - If mplier[0]==1, acc <= acc + mcand (64-bit, no carry-out).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - After the 32nd iteration (cnt==31 this cycle), go to DONE.
- DONE:
  - result_o = neg_flag ? (~acc+1) : acc; ready_o=1.
  - Stays in DONE while start_i=1.
  - start_i=0: go to IDLE next cycle; ready_o and result_o clear to 0.
- Latency, with start sampled at edge T:
  - Normal operation: ready_o high from T+33.
  - Zero-operand fast path: ready_o high from T+1.
- annul_i=1 in CALC or DONE: go to IDLE next cycle; ready_o=0, result_o=0. No result is produced.
- annul_i has priority over start_i in every state.
- start_i with annul_i in the same IDLE cycle: the request is ignored.
- A new start_i in the same cycle DONE goes to IDLE is not possible by protocol: start_i is low in that cycle. A new request is accepted one cycle later.
- All outputs are registered. There is no combinational path from any input to any output.

Optional Feature:
- Macro: MUL_SEQ_EARLY_OUT_EN.
- Defined: in CALC, if the next-cycle mplier equals 0, go to DONE immediately. Latency becomes (index of highest set bit of |op2|) + 2 cycles.
  - Example: |op2|=7 gives ready_o at T+4.
- Not defined: every non-zero operation takes exactly 32 CALC cycles, so ready_o appears at T+33.
- The zero-operand fast path is always present, with or without the macro.

Decomposition:
- Shared package/defines.v:
  - MulType encodings: MulTypeMUL=2'b00, MulTypeMULH=2'b01, MulTypeMULHSU=2'b10, MulTypeMULHU=2'b11.
  - State encodings: MulIdle, MulCalc, MulDone.
  - MulResultReady / MulResultNotReady, MulStart / MulStop, mirroring the Div* defines.
- No sub-module. FSM, datapath and sign logic stay in one file.
- The ex stage gets a small wrapper change: it drives start_i and stallreq_for_mul the same way it does for div.

Test Plan:
- MULHU, 0xFFFFFFFF * 0xFFFFFFFF, start at T -> ready_o=1 at T+33, result_o=0xFFFFFFFE_00000001.
- MUL, 0xFFFFFFFD(-3) * 0x00000007 -> result_o=0xFFFFFFFF_FFFFFFEB; ready_o stays 1 until start_i drops, then clears next cycle.
- MULH, 0x80000000 * 0x80000000 -> 0x40000000_00000000. MULHSU, 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF_00000001.
- Operand 0 (0x12345678 * 0) -> ready_o at T+1, result_o=0. Also verify start_i+annul_i together in IDLE -> state remains IDLE.
- Abort and reset:
  - annul_i at T+10 mid-CALC -> IDLE at T+11; ready_o never asserts; a fresh start at T+12 completes correctly at T+45.
  - rst low mid-CALC -> all outputs 0 immediately, without a clock edge.
- With MUL_SEQ_EARLY_OUT_EN defined: MULHU 5 * 7 -> ready_o at T+4, result_o=35. Without the macro the same operation completes at T+33.
